led_pwm_ctrl: RTL
=================

Name: led_pwm_ctrl

Overview:
- Parametrised multi-channel LED driver for Schoko SoC top levels.
- Replaces fixed LED wiring (free-running blink counter, direct port bits) with a per-channel register-programmed mode: off, PWM on, PWM blink, or follow an external bit.
- Sits between the SoC port/bus write path and the board LED pins; drives pins directly at board polarity.

Parameters:
- CHANNELS, 3, number of LED outputs (1..8).
- PWM_BITS, 8, PWM counter and duty width.
- PRESCALE_BITS, 27, free-running blink prescaler width.
- ACTIVE_LOW, 1, 1 = pin driven low when LED lit.

Ports:
- sysClock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  config write strobe.
- addr  in  3  channel index for write and read.
- wr_data  in  PWM_BITS+7  {mode[1:0], blink_sel[4:0], duty[PWM_BITS-1:0]}.
- rd_data  out  PWM_BITS+7  registered config readback of channel addr.
- ext_in  in  CHANNELS  external drive bits (e.g. SoC port_a).
- period_tick  out  1  one-cycle pulse when PWM counter wraps.
- led  out  CHANNELS  LED pins.

Behaviour:
- Prescaler: PRESCALE_BITS counter, +1 every cycle, wraps to 0.
- PWM counter: PWM_BITS counter, +1 every cycle, wraps all-ones -> 0.
- period_tick is registered and is 1 in the cycle after the counter holds all-ones, i.e. aligned with count 0.
- Per channel, pwm_on is (pwm_cnt < duty). duty = all-ones forces pwm_on = 1 constantly. duty = 0 gives constant off.
- Modes:
  - 0 OFF: lit = 0.
  - 1 ON: lit = pwm_on.
  - 2 BLINK: lit = pwm_on & prescaler[blink_sel]. blink_sel >= PRESCALE_BITS is clamped to PRESCALE_BITS-1.
  - 3 EXT: lit = ext_in[ch], passed through one register stage.
- Output: led[ch] is registered, one cycle after lit is evaluated. Pin level is lit ^ ACTIVE_LOW.
- Writes:
  - With wr_en=1 and addr < CHANNELS, the config updates at the clock edge and is visible to lit on the next cycle.
  - With addr >= CHANNELS the write is ignored.
- Reads: rd_data = config[addr], registered with 1-cycle latency; returns 0 when addr >= CHANNELS. The read is independent of wr_en. A write and a read of the same addr in one cycle returns the old value.
- Reset values: counters 0; all configs 0 (OFF, blink_sel 0, duty 0); rd_data 0; period_tick 0; led all at inactive level (all 1s when ACTIVE_LOW=1).
- Reset asserted mid-period clears everything in the same edge. reset has priority over wr_en.
- No handshake: wr_en is always accepted in a single cycle.

Optional Feature:
- LED_SHADOW_EN defined:
  - duty and mode writes go to a per-channel shadow register.
  - Shadows commit to the active config on the cycle the PWM counter wraps to 0, so each period stays glitch-free.
  - rd_data returns the shadow value.
  - Reset clears both shadow and active registers.
- Undefined: writes update the active config immediately, as described above.

Decomposition:
- Package led_pkg:
  - led_mode_t enum {LED_OFF, LED_ON, LED_BLINK, LED_EXT}.
  - led_cfg_t packed struct {mode, blink_sel, duty}, parameterised on PWM_BITS via localparam default 8.
  - Field-width constants.
- Sub-module led_channel: one config (+shadow) register, mode mux and output flop, instantiated CHANNELS times by generate. The top owns the counters, address decode and readback.

Test Plan:
- PWM duty: reset, write ch0 {ON, duty=64}; count lit cycles over 256 cycles after period_tick -> exactly 64, all contiguous from count 0. duty=255 -> 256 of 256. duty=0 -> 0.
- Blink gating: write ch1 {BLINK, blink_sel=3, duty=255} -> led[1] alternates 8 cycles lit / 8 cycles dark, pin low when lit (ACTIVE_LOW=1). blink_sel=31 behaves as bit 26.
- External mode: write ch2 {EXT}; toggle ext_in[2] -> led[2] follows with 2-cycle total latency, inverted.
- Addressing: with CHANNELS=3, write addr=3 -> no output change and rd_data of addr 3 = 0. Read of addr 0 after a write returns the written word one cycle after addr is applied.
- Reset mid-operation: assert reset during an ON duty=128 period together with wr_en -> next cycle led = 3'b111, rd_data = 0, period_tick = 0, and counters restart from 0 on release.
- LED_SHADOW_EN: change duty 64 -> 192 at pwm_cnt=100 -> current period still ends lit-count 64; next period gives 192.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and field widths for the multi-channel LED PWM driver.
package led_pkg;

  localparam int LED_PWM_BITS     = 8;
  localparam int LED_MODE_W       = 2;
  localparam int LED_BLINK_SEL_W  = 5;
  localparam int LED_CFG_EXTRA_W  = LED_MODE_W + LED_BLINK_SEL_W;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_EXT   = 2'd3
  } led_mode_t;

  typedef struct packed {
    led_mode_t                    mode;
    logic [LED_BLINK_SEL_W-1:0]   blink_sel;
    logic [LED_PWM_BITS-1:0]      duty;
  } led_cfg_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: config register (plus shadow when LED_SHADOW_EN is
// defined), mode mux and registered pin driver.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 27,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_wr_en,
  input  logic [PWM_BITS+LED_CFG_EXTRA_W-1:0] i_wr_data,
`ifdef LED_SHADOW_EN
  input  logic                                i_commit,
`endif
  input  logic [PWM_BITS-1:0]                 i_pwm_cnt,
  input  logic [PRESCALE_BITS-1:0]            i_prescale,
  input  logic                                i_ext,
  output logic [PWM_BITS+LED_CFG_EXTRA_W-1:0] o_cfg,
  output logic                                o_led
);

  localparam int   CFG_W      = PWM_BITS + LED_CFG_EXTRA_W;
  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);

  logic [CFG_W-1:0]           r_cfg;
  logic                       r_ext;
  logic                       r_led;
  led_mode_t                  w_mode;
  logic [LED_BLINK_SEL_W-1:0] w_sel;
  logic [LED_BLINK_SEL_W-1:0] w_selClamped;
  logic [PWM_BITS-1:0]        w_duty;
  logic                       w_pwmOn;
  logic                       w_blinkBit;
  logic                       w_lit;

  assign w_mode = led_mode_t'(r_cfg[CFG_W-1 -: LED_MODE_W]);
  assign w_sel  = r_cfg[PWM_BITS +: LED_BLINK_SEL_W];
  assign w_duty = r_cfg[PWM_BITS-1:0];

`ifdef LED_SHADOW_EN
  logic [CFG_W-1:0] r_shadow;

  // Writes land in the shadow; the active config only changes at a PWM wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= '0;
      r_cfg    <= '0;
    end else begin
      if (i_wr_en) r_shadow <= i_wr_data;
      if (i_commit) r_cfg <= r_shadow;
    end
  end

  assign o_cfg = r_shadow;
`else
  // Writes update the active config directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cfg <= '0;
    end else if (i_wr_en) begin
      r_cfg <= i_wr_data;
    end
  end

  assign o_cfg = r_cfg;
`endif

  // Decide whether the LED is lit this cycle from mode, duty and blink tap.
  always_comb begin
    w_selClamped = w_sel;
    if (32'(w_sel) >= PRESCALE_BITS) w_selClamped = LED_BLINK_SEL_W'(PRESCALE_BITS - 1);
    w_blinkBit = |(i_prescale & (PRESCALE_BITS'(1) << w_selClamped));
    w_pwmOn    = (w_duty == '1) || (i_pwm_cnt < w_duty);
    w_lit      = 1'b0;
    case (w_mode)
      LED_OFF:   w_lit = 1'b0;
      LED_ON:    w_lit = w_pwmOn;
      LED_BLINK: w_lit = w_pwmOn & w_blinkBit;
      LED_EXT:   w_lit = r_ext;
      default:   w_lit = 1'b0;
    endcase
  end

  // Register the external bit and the pin so outputs are glitch-free.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ext <= 1'b0;
      r_led <= IDLE_LEVEL;
    end else begin
      r_ext <= i_ext;
      r_led <= w_lit ^ IDLE_LEVEL;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: shared prescaler and PWM counter, address
// decode, registered readback, and one led_channel per output pin.
// Define LED_SHADOW_EN to buffer config writes until the next PWM wrap.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 27,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                                sysClock,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [2:0]                          addr,
  input  logic [PWM_BITS+LED_CFG_EXTRA_W-1:0] wr_data,
  output logic [PWM_BITS+LED_CFG_EXTRA_W-1:0] rd_data,
  input  logic [CHANNELS-1:0]                 ext_in,
  output logic                                period_tick,
  output logic [CHANNELS-1:0]                 led
);

  localparam int CFG_W = PWM_BITS + LED_CFG_EXTRA_W;

  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [PWM_BITS-1:0]      r_pwmCnt;
  logic                     r_periodTick;
  logic [CFG_W-1:0]         r_rdData;
  logic [CHANNELS-1:0]      w_wrSel;
  logic [CFG_W-1:0]         w_cfg [CHANNELS];
  logic [CFG_W-1:0]         w_rdMux;

`ifdef LED_SHADOW_EN
  logic w_commit;
  assign w_commit = (r_pwmCnt == '1);
`endif

  // Free-running prescaler and PWM counter; tick marks the wrap to zero.
  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_prescale   <= '0;
      r_pwmCnt     <= '0;
      r_periodTick <= 1'b0;
    end else begin
      r_prescale   <= r_prescale + PRESCALE_BITS'(1);
      r_pwmCnt     <= r_pwmCnt + PWM_BITS'(1);
      r_periodTick <= (r_pwmCnt == '1);
    end
  end

  // Select the addressed channel's config; out-of-range addresses read 0.
  always_comb begin
    w_rdMux = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (addr == 3'(ch)) w_rdMux = w_cfg[ch];
    end
  end

  // Readback is registered, so a same-cycle write shows the old value.
  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= w_rdMux;
    end
  end

  assign rd_data     = r_rdData;
  assign period_tick = r_periodTick;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    assign w_wrSel[g] = wr_en && (addr == 3'(g));

    led_channel #(
      .PWM_BITS      (PWM_BITS),
      .PRESCALE_BITS (PRESCALE_BITS),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_channel (
      .i_clk      (sysClock),
      .i_reset    (reset),
      .i_wr_en    (w_wrSel[g]),
      .i_wr_data  (wr_data),
`ifdef LED_SHADOW_EN
      .i_commit   (w_commit),
`endif
      .i_pwm_cnt  (r_pwmCnt),
      .i_prescale (r_prescale),
      .i_ext      (ext_in[g]),
      .o_cfg      (w_cfg[g]),
      .o_led      (led[g])
    );
  end

endmodule
